// File: rtl/flit_depacketizer.sv
// flit_depacketizer: per-VC packet reassembly from router flits into a tagged valid/ready word stream
module flit_depacketizer #(
  parameter int FLIT_W     = 38,
  parameter int VC_W       = 4,
  parameter int NUM_VC     = 4,
  parameter int CLASS_W    = 3,
  parameter int MAX_BODY   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flit_in_we,
  input  logic [FLIT_W-1:0]        flit_in,
  output logic                     credit_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FLIT_W-VC_W-3:0]   out_data,
  output logic [CLASS_W-1:0]       out_class,
  output logic [VC_W-1:0]          out_vc,
  output logic                     out_first,
  output logic                     out_last,
  output logic                     err_orphan,
  output logic                     err_overrun,
  output logic                     err_length,
  output logic                     err_overflow
);
  localparam int DATA_W = FLIT_W - 2 - VC_W;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = $clog2(MAX_BODY + 1);
  localparam int IW     = NUM_VC > 1 ? $clog2(NUM_VC) : 1;
  logic [FLIT_W-1:0]  mem [FIFO_DEPTH];
  logic [AW:0]        wp, rp;
  logic               act    [NUM_VC];
  logic [CLASS_W-1:0] ccls   [NUM_VC];
  logic [CW-1:0]      ccnt   [NUM_VC];
  logic               cfirst [NUM_VC];
  logic               empty, full, pop, wr;
  logic [FLIT_W-1:0]  f;
  logic [1:0]         ft;
  logic [VC_W-1:0]    fvc;
  logic [CLASS_W-1:0] fcls;
  logic [DATA_W-1:0]  fdata;
  logic [IW-1:0]      idx;
  logic               vc_ok, a, len_full, orphan, overrun, len_err, emit;
  always_comb begin
    empty    = wp == rp;
    full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    pop      = !empty && (!out_valid || out_ready);
    wr       = flit_in_we && (!full || pop);
    f        = mem[rp[AW-1:0]];
    ft       = f[FLIT_W-1:FLIT_W-2];
    fvc      = f[FLIT_W-3 -: VC_W];
    fcls     = f[FLIT_W-3-VC_W -: CLASS_W];
    fdata    = f[DATA_W-1:0];
    vc_ok    = int'(fvc) < NUM_VC;
    idx      = vc_ok ? fvc[IW-1:0] : '0;
    a        = vc_ok && act[idx];
    len_full = ccnt[idx] == CW'(MAX_BODY);
    // ft[1] marks a head, ft[0] a tail; any flit on an invalid VC is dropped as an orphan
    orphan   = !vc_ok || (!ft[1] && !a);
    overrun  = ft[1] && a;
    len_err  = !ft[1] && !ft[0] && a && len_full;
    emit     = vc_ok && (ft == 2'b11 || (!ft[1] && a && !len_full));
    credit_out = pop;
  end
  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= flit_in;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp           <= '0;
      rp           <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_class    <= '0;
      out_vc       <= '0;
      out_first    <= 1'b0;
      out_last     <= 1'b0;
      err_orphan   <= 1'b0;
      err_overrun  <= 1'b0;
      err_length   <= 1'b0;
      err_overflow <= 1'b0;
      for (int i = 0; i < NUM_VC; i++) begin
        act[i]    <= 1'b0;
        ccls[i]   <= '0;
        ccnt[i]   <= '0;
        cfirst[i] <= 1'b0;
      end
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      err_overflow <= flit_in_we && full && !pop;
      err_orphan   <= pop && orphan;
      err_overrun  <= pop && overrun;
      err_length   <= pop && len_err;
      if (pop && emit) begin
        out_valid <= 1'b1;
        out_data  <= fdata;
        out_class <= ft[1] ? fcls : ccls[idx];
        out_vc    <= fvc;
        out_first <= ft[1] || cfirst[idx];
        out_last  <= ft[0];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (pop && vc_ok) begin
        if (ft == 2'b10) begin
          act[idx]    <= 1'b1;
          ccls[idx]   <= fcls;
          ccnt[idx]   <= '0;
          cfirst[idx] <= 1'b1;
        end else if (ft == 2'b11) begin
          act[idx] <= 1'b0;
        end else if (a) begin
          if (ft[0]) act[idx] <= 1'b0;
          else if (!len_full) begin
            ccnt[idx]   <= ccnt[idx] + 1'b1;
            cfirst[idx] <= 1'b0;
          end
        end
      end
    end
endmodule

// File: tb/tb_flit_depacketizer.sv
// tb_flit_depacketizer: scoreboard bench for flit reassembly, handshake, credits and error pulses
module tb_flit_depacketizer;
  localparam int FLIT_W = 38, VC_W = 4, CLASS_W = 3, DATA_W = 32, MAX_BODY = 8, FIFO_DEPTH = 4;
  logic clk = 0, reset = 1, flit_in_we = 0, out_ready = 1;
  logic [FLIT_W-1:0] flit_in = '0;
  logic credit_out, out_valid, out_first, out_last;
  logic err_orphan, err_overrun, err_length, err_overflow;
  logic [DATA_W-1:0] out_data;
  logic [CLASS_W-1:0] out_class;
  logic [VC_W-1:0] out_vc;
  int checks = 0, errors = 0;
  int n_credit = 0, n_orphan = 0, n_overrun = 0, n_length = 0, n_overflow = 0;
  logic [63:0] sb[$];
  logic [63:0] cur, prev;
  logic stalled = 0;

  flit_depacketizer dut (
    .clk(clk), .reset(reset), .flit_in_we(flit_in_we), .flit_in(flit_in),
    .credit_out(credit_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_class(out_class), .out_vc(out_vc),
    .out_first(out_first), .out_last(out_last), .err_orphan(err_orphan),
    .err_overrun(err_overrun), .err_length(err_length), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] word(input logic [31:0] d, input logic [2:0] c,
                                       input logic [3:0] v, input logic fst, input logic lst);
    return {23'b0, d, c, v, fst, lst};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [1:0] t, input logic [3:0] v, input logic [31:0] p);
    flit_in_we = 1;
    flit_in = {t, v, p};
    @(posedge clk); #1;
    flit_in_we = 0;
  endtask

  task automatic hd(input logic [3:0] v, input logic [2:0] c);
    send(2'b10, v, {c, 29'b0});
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) idle(1);
    check("drain_left", 64'(sb.size()), 64'd0);
    idle(3);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      cur = word(out_data, out_class, out_vc, out_first, out_last);
      if (stalled) check("hold", cur, prev);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_word", {63'b0, out_valid}, 64'd0);
        else check("word", cur, sb.pop_front());
      end
      stalled = out_valid && !out_ready;
      prev = cur;
      if (credit_out) n_credit++;
      if (err_orphan) n_orphan++;
      if (err_overrun) n_overrun++;
      if (err_length) n_length++;
      if (err_overflow) n_overflow++;
    end else stalled = 0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, o0, v0, l0, f0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {63'b0, out_valid}, 64'd0);
    check("rst_credit", {63'b0, credit_out}, 64'd0);
    check("rst_word", word(out_data, out_class, out_vc, out_first, out_last), 64'd0);
    check("rst_errs", {60'b0, err_orphan, err_overrun, err_length, err_overflow}, 64'd0);
    reset = 0;
    idle(2);
    // T1: head + tail back-to-back
    c0 = n_credit;
    sb.push_back(word(32'h180, 3'd2, 4'd1, 1, 1));
    hd(4'd1, 3'd2);
    send(2'b01, 4'd1, 32'h180);
    drain();
    check("t1_credits", 64'(n_credit - c0), 64'd2);
    // T2: multi-word packet with a 3-cycle stall on word 2
    sb.push_back(word(32'h7E0, 3'd3, 4'd1, 1, 0));
    sb.push_back(word(32'h7E0, 3'd3, 4'd1, 0, 0));
    sb.push_back(word(32'h707, 3'd3, 4'd1, 0, 1));
    hd(4'd1, 3'd3);
    send(2'b00, 4'd1, 32'h7E0);
    send(2'b00, 4'd1, 32'h7E0);
    send(2'b01, 4'd1, 32'h707);
    out_ready = 0;
    idle(3);
    out_ready = 1;
    drain();
    // T3: interleaved VCs
    sb.push_back(word(32'h11, 3'd1, 4'd0, 1, 0));
    sb.push_back(word(32'h22, 3'd6, 4'd2, 1, 1));
    sb.push_back(word(32'h33, 3'd1, 4'd0, 0, 1));
    hd(4'd0, 3'd1);
    hd(4'd2, 3'd6);
    send(2'b00, 4'd0, 32'h11);
    send(2'b01, 4'd2, 32'h22);
    send(2'b01, 4'd0, 32'h33);
    drain();
    // T4: orphan, invalid VC, overrun, head+tail
    o0 = n_orphan; v0 = n_overrun;
    send(2'b01, 4'd3, 32'h99);
    send(2'b00, 4'd9, 32'h98);
    idle(4);
    check("t4_orphan", 64'(n_orphan - o0), 64'd2);
    sb.push_back(word(32'h44, 3'd5, 4'd1, 1, 1));
    hd(4'd1, 3'd4);
    hd(4'd1, 3'd5);
    send(2'b01, 4'd1, 32'h44);
    drain();
    check("t4_overrun", 64'(n_overrun - v0), 64'd1);
    sb.push_back(word(32'hA000_0123, 3'd5, 4'd2, 1, 1));
    send(2'b11, 4'd2, 32'hA000_0123);
    drain();
    // T5: MAX_BODY+2 bodies
    o0 = n_orphan; l0 = n_length;
    hd(4'd0, 3'd7);
    for (int i = 0; i < MAX_BODY + 2; i++) begin
      if (i < MAX_BODY) sb.push_back(word(32'h500 + i, 3'd7, 4'd0, i == 0, 0));
      send(2'b00, 4'd0, 32'h500 + i);
    end
    send(2'b01, 4'd0, 32'h5FF);
    drain();
    check("t5_length", 64'(n_length - l0), 64'd2);
    check("t5_tail_orphan", 64'(n_orphan - o0), 64'd0);
    send(2'b01, 4'd0, 32'h5FE);
    idle(4);
    check("t5_idle_after", 64'(n_orphan - o0), 64'd1);
    // T6: overflow while stalled, then reset mid-packet
    f0 = n_overflow;
    out_ready = 0;
    hd(4'd1, 3'd2);
    for (int i = 0; i < FIFO_DEPTH + 3; i++) send(2'b00, 4'd1, 32'h100 + i);
    idle(1);
    check("t6_overflow", 64'(n_overflow - f0), 64'd2);
    c0 = n_credit;
    idle(3);
    check("t6_no_credit", 64'(n_credit - c0), 64'd0);
    check("t6_valid_held", {63'b0, out_valid}, 64'd1);
    reset = 1;
    #1;
    check("t6_rst_valid", {63'b0, out_valid}, 64'd0);
    check("t6_rst_credit", {63'b0, credit_out}, 64'd0);
    check("t6_rst_word", word(out_data, out_class, out_vc, out_first, out_last), 64'd0);
    idle(2);
    reset = 0;
    out_ready = 1;
    o0 = n_orphan;
    send(2'b01, 4'd1, 32'h77);
    idle(4);
    check("t6_ctx_cleared", 64'(n_orphan - o0), 64'd1);
    check("final_sb", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
